// File: rtl/stream_arb_mux_2_1.sv
// stream_arb_mux_2_1
// Packet-aware 2:1 stream arbiter with a single registered output stage.
// Two valid/ready sources (a, b) compete round-robin; the winner keeps the
// output for its whole packet (through the beat with last=1). The source of
// every output beat is reported on o_cs so companion mux paths can follow.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   a_data/valid/last   channel a input beat
//   a_ready             channel a beat accepted this cycle
//   b_data/valid/last   channel b input beat
//   b_ready             channel b beat accepted this cycle
//   o_data/valid/last   registered output beat
//   o_cs                source of the output beat: 0=a, 1=b
//   o_ready             downstream accepts the output beat
//
// state  | meaning
// IDLE   | no packet in progress; grant by valid, pointer breaks ties
// LOCK_A | a is mid-packet; only a may be served (bubbles allowed)
// LOCK_B | b is mid-packet; only b may be served (bubbles allowed)

module stream_arb_mux_2_1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_last,
  output logic             o_cs,
  input  logic             o_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_ptr;      // tie-break pointer: 0=a, 1=b
  logic [WIDTH-1:0] r_o_data;
  logic             r_o_valid;
  logic             r_o_last;
  logic             r_o_cs;

  logic             w_load;
  logic             w_gnt_vld;
  logic             w_gnt_sel;
  logic             w_src_valid;
  logic             w_src_last;
  logic [WIDTH-1:0] w_src_data;
  logic             w_xfer;

  // Output register can take a new beat when empty or being drained.
  assign w_load = !r_o_valid || o_ready;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_sel = 1'b0;
    case (r_state)
      IDLE: begin
        if (a_valid && b_valid) begin
          w_gnt_vld = 1'b1;
          w_gnt_sel = r_ptr;
        end else if (a_valid) begin
          w_gnt_vld = 1'b1;
          w_gnt_sel = 1'b0;
        end else if (b_valid) begin
          w_gnt_vld = 1'b1;
          w_gnt_sel = 1'b1;
        end
      end
      // Locked states grant their owner even when it has nothing to send,
      // so the other source cannot slip a beat into the packet.
      LOCK_A: begin
        w_gnt_vld = 1'b1;
        w_gnt_sel = 1'b0;
      end
      LOCK_B: begin
        w_gnt_vld = 1'b1;
        w_gnt_sel = 1'b1;
      end
      default: begin
        w_gnt_vld = 1'b0;
        w_gnt_sel = 1'b0;
      end
    endcase
  end

  assign w_src_valid = w_gnt_sel ? b_valid : a_valid;
  assign w_src_last  = w_gnt_sel ? b_last  : a_last;
  assign w_src_data  = w_gnt_sel ? b_data  : a_data;

  assign w_xfer = w_load && w_gnt_vld && w_src_valid;

  // Readies are masked during reset so no beat is consumed and then dropped.
  assign a_ready = !rst && w_load && w_gnt_vld && !w_gnt_sel;
  assign b_ready = !rst && w_load && w_gnt_vld &&  w_gnt_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_o_data  <= '0;
      r_o_valid <= 1'b0;
      r_o_last  <= 1'b0;
      r_o_cs    <= 1'b0;
    end else begin
      if (w_load) begin
        r_o_valid <= w_xfer;
      end
      if (w_xfer) begin
        r_o_data <= w_src_data;
        r_o_last <= w_src_last;
        r_o_cs   <= w_gnt_sel;
        if (w_src_last) begin
          // Packet done (including single-beat packets from IDLE):
          // release the lock and favour the other source next time.
          r_state <= IDLE;
          r_ptr   <= !w_gnt_sel;
        end else begin
          r_state <= w_gnt_sel ? LOCK_B : LOCK_A;
        end
      end
    end
  end

  assign o_data  = r_o_data;
  assign o_valid = r_o_valid;
  assign o_last  = r_o_last;
  assign o_cs    = r_o_cs;

endmodule

// File: tb/tb_stream_arb_mux_2_1.sv
module tb_stream_arb_mux_2_1;

  logic       clk;
  logic       rst;
  logic [7:0] a_data, b_data, o_data;
  logic       a_valid, a_last, a_ready;
  logic       b_valid, b_last, b_ready;
  logic       o_valid, o_last, o_cs, o_ready;

  stream_arb_mux_2_1 #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .a_data (a_data),
    .a_valid(a_valid),
    .a_last (a_last),
    .a_ready(a_ready),
    .b_data (b_data),
    .b_valid(b_valid),
    .b_last (b_last),
    .b_ready(b_ready),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_last (o_last),
    .o_cs   (o_cs),
    .o_ready(o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [8:0] a_q[$];      // {data, last}
  logic [8:0] b_q[$];
  logic [9:0] exp_q[$];    // {data, last, cs}

  logic       rst_req  = 1'b1;
  logic       a_en     = 1'b1;
  logic       b_en     = 1'b1;
  int         stall_left = 0;
  logic [7:0] stall_data = 8'h00;
  logic       stalling = 1'b0;
  logic       pend_vld = 1'b0;
  logic [9:0] pend_beat;
  logic       a_in_pkt = 1'b0;
  logic       b_in_pkt = 1'b0;
  logic       nobubble = 1'b0;
  logic       have_prev = 1'b0;
  int         cyc = 0;
  int         last_out_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, settle, then evaluate the
  // handshakes that the next rising edge will perform.
  task automatic step();
    logic [9:0] e;
    @(negedge clk);
    cyc++;
    rst = rst_req;
    if (stall_left > 0 && o_valid === 1'b1 && o_data === stall_data) begin
      o_ready = 1'b0;
      stall_left--;
      stalling = 1'b1;
    end else begin
      o_ready = 1'b1;
      stalling = 1'b0;
    end
    a_valid = a_en && (a_q.size() > 0);
    if (a_q.size() > 0) {a_data, a_last} = a_q[0];
    b_valid = b_en && (b_q.size() > 0);
    if (b_q.size() > 0) {b_data, b_last} = b_q[0];
    #1;
    if (rst) begin
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      pend_vld = 1'b0;
      a_in_pkt = 1'b0;
      b_in_pkt = 1'b0;
    end else begin
      if (pend_vld) begin
        chk("lat_valid", o_valid, 1);
        chk("lat_beat", {o_data, o_last, o_cs}, pend_beat);
        pend_vld = 1'b0;
      end
      chk("ready_excl", a_ready && b_ready, 0);
      if (a_in_pkt) chk("lock_b_ready", b_ready, 0);
      if (b_in_pkt) chk("lock_a_ready", a_ready, 0);
      if (stalling) begin
        chk("stall_data", o_data, stall_data);
        chk("stall_valid", o_valid, 1);
        chk("stall_cs", o_cs, 0);
        chk("stall_a_ready", a_ready, 0);
        chk("stall_b_ready", b_ready, 0);
      end
      if (o_valid === 1'b1 && o_ready) begin
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_beat", {o_data, o_last, o_cs}, e);
        end
        if (nobubble && have_prev) chk("no_bubble", cyc - last_out_cyc, 1);
        have_prev = 1'b1;
        last_out_cyc = cyc;
      end
      if (a_valid && a_ready) begin
        pend_vld  = 1'b1;
        pend_beat = {a_data, a_last, 1'b0};
        a_in_pkt  = !a_last;
        void'(a_q.pop_front());
      end
      if (b_valid && b_ready) begin
        pend_vld  = 1'b1;
        pend_beat = {b_data, b_last, 1'b1};
        b_in_pkt  = !b_last;
        void'(b_q.pop_front());
      end
    end
  endtask

  task automatic run(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    step();
    step();
    rst_req = 1'b0;
    have_prev = 1'b0;
  endtask

  initial begin
    rst = 1'b1; o_ready = 1'b1;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;

    // Reset with both sources valid; a wins first afterwards.
    a_q.push_back({8'h55, 1'b1});
    b_q.push_back({8'hC5, 1'b1});
    rst_req = 1'b1;
    step();
    step();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_cs", o_cs, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_last", o_last, 0);
    rst_req = 1'b0;
    exp_q.push_back({8'h55, 1'b1, 1'b0});
    exp_q.push_back({8'hC5, 1'b1, 1'b1});
    run("reset_first", 20);

    // Single source streaming.
    do_reset();
    foreach (exp_q[i]) ;
    a_q.push_back({8'h11, 1'b0}); a_q.push_back({8'h22, 1'b0});
    a_q.push_back({8'h33, 1'b0}); a_q.push_back({8'h44, 1'b1});
    exp_q.push_back({8'h11, 1'b0, 1'b0}); exp_q.push_back({8'h22, 1'b0, 1'b0});
    exp_q.push_back({8'h33, 1'b0, 1'b0}); exp_q.push_back({8'h44, 1'b1, 1'b0});
    nobubble = 1'b1;
    run("single", 20);
    nobubble = 1'b0;

    // Packet lock and fairness.
    do_reset();
    a_q.push_back({8'hA1, 1'b0}); a_q.push_back({8'hA2, 1'b0}); a_q.push_back({8'hA3, 1'b1});
    b_q.push_back({8'hB1, 1'b0}); b_q.push_back({8'hB2, 1'b1});
    exp_q.push_back({8'hA1, 1'b0, 1'b0}); exp_q.push_back({8'hA2, 1'b0, 1'b0});
    exp_q.push_back({8'hA3, 1'b1, 1'b0});
    exp_q.push_back({8'hB1, 1'b0, 1'b1}); exp_q.push_back({8'hB2, 1'b1, 1'b1});
    run("lock", 30);

    // Round-robin alternation of single-beat packets.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      a_q.push_back({8'(i), 1'b1});
      b_q.push_back({8'(8'h80 + i), 1'b1});
      exp_q.push_back({8'(i), 1'b1, 1'b0});
      exp_q.push_back({8'(8'h80 + i), 1'b1, 1'b1});
    end
    nobubble = 1'b1;
    run("rr", 30);
    nobubble = 1'b0;

    // Backpressure for 3 cycles on output beat 0x22.
    do_reset();
    stall_data = 8'h22;
    stall_left = 3;
    a_q.push_back({8'h11, 1'b0}); a_q.push_back({8'h22, 1'b0});
    a_q.push_back({8'h33, 1'b0}); a_q.push_back({8'h44, 1'b1});
    exp_q.push_back({8'h11, 1'b0, 1'b0}); exp_q.push_back({8'h22, 1'b0, 1'b0});
    exp_q.push_back({8'h33, 1'b0, 1'b0}); exp_q.push_back({8'h44, 1'b1, 1'b0});
    run("bp", 30);
    chk("bp_stall_used", stall_left, 0);

    // Lock bubble, then reset mid-packet.
    do_reset();
    a_q.push_back({8'h61, 1'b0}); a_q.push_back({8'h62, 1'b1});
    b_q.push_back({8'h91, 1'b1});
    exp_q.push_back({8'h61, 1'b0, 1'b0});
    for (int n = 0; n < 10 && a_q.size() > 1; n++) step();
    chk("bubble_a_taken", a_q.size(), 1);
    a_en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("bubble_b_ready", b_ready, 0);
    end
    chk("bubble_drained", exp_q.size(), 0);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    a_q.delete();
    a_en = 1'b1;
    exp_q.push_back({8'h91, 1'b1, 1'b1});
    step();
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_b_ready", b_ready, 1);
    run("midrst", 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
